debug_reg_dumper: RTL and testbench

- Host-side counterpart of the processor's debug read port.
- Drives the processor's 5-bit debug source select and samples the 32-bit debug output for each register x0..x31, one register at a time.
- Serialises each captured word over a UART 8N1 line for bench/board inspection.
- Sits beside the single-cycle core at board top level, on the same clock.

---
 rtl/debug_dump_pkg.sv | 41 ++++
 rtl/debug_uart_tx.sv | 91 +++++++++
 rtl/debug_reg_dumper.sv | 135 +++++++++++++
 tb/tb_debug_reg_dumper.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_dump_pkg.sv
// Shared constants and helpers for the debug register dumper.
// DEBUG_DUMP_HEX_ASCII_EN selects hex-ASCII lines instead of raw bytes per register.
package debug_dump_pkg;

  // Sweep controller states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_LOAD    = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;

  // Serialiser states
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;
  localparam int   DATA_BITS  = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef DEBUG_DUMP_HEX_ASCII_EN
  localparam int FRAMES_PER_REG = 10;
  localparam int BYTE_CNT_W     = 4;
`else
  localparam int FRAMES_PER_REG = 4;
  localparam int BYTE_CNT_W     = 2;
`endif

  function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
    if (nib < 4'd10)
      return 8'h30 + {4'h0, nib};
    else
      return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/debug_uart_tx.sv
// Byte-wide 8N1 transmitter. A load during the final stop-bit cycle chains the
// next frame with no idle gap.
module debug_uart_tx
  import debug_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic [1:0]        state_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic              tx_reg;
  logic              bit_end;

  assign bit_end = (baud_reg == BAUD_LAST);
  assign tx      = tx_reg;
  assign tx_done = (state_reg == TX_STOP) && bit_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= TX_IDLE;
      baud_reg    <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= UART_STOP;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          if (load) begin
            shift_reg <= data;
            baud_reg  <= '0;
            tx_reg    <= UART_START;
            state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            baud_reg    <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= shift_reg[0];
            state_reg   <= TX_DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
              tx_reg    <= UART_STOP;
              state_reg <= TX_STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: begin
          if (bit_end) begin
            baud_reg <= '0;
            if (load) begin
              shift_reg <= data;
              tx_reg    <= UART_START;
              state_reg <= TX_START;
            end else begin
              state_reg <= TX_IDLE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/debug_reg_dumper.sv
// Sweeps the processor debug select over x0..x(NUM_REGS-1) and streams each word
// out over UART. DEBUG_DUMP_HEX_ASCII_EN sends 8 hex chars + CR LF per register.
module debug_reg_dumper
  import debug_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Debug_out,
  output logic [4:0]  Debug_source_select,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int FRAME_SLOTS = 1 << BYTE_CNT_W;
  localparam logic [4:0] IDX_LAST = 5'(NUM_REGS - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(FRAMES_PER_REG - 1);

  logic [2:0]            state_reg;
  logic [4:0]            idx_reg;
  logic [31:0]           word_reg;
  logic [BYTE_CNT_W-1:0] byte_cnt_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  load;
  logic [BYTE_CNT_W-1:0] byte_sel;
  logic [7:0]            load_data;
  logic                  tx_done;
  logic                  last_frame;
  logic [7:0]            frame_bytes [FRAME_SLOTS];

  // Per-frame payload of the captured word, most significant part first.
  generate
    for (genvar gi = 0; gi < FRAME_SLOTS; gi++) begin : g_frame
`ifdef DEBUG_DUMP_HEX_ASCII_EN
      if (gi < 8) begin : g_hex
        assign frame_bytes[gi] = nibble_to_hex(word_reg[31-4*gi -: 4]);
      end else if (gi == 8) begin : g_cr
        assign frame_bytes[gi] = ASCII_CR;
      end else if (gi == 9) begin : g_lf
        assign frame_bytes[gi] = ASCII_LF;
      end else begin : g_pad
        assign frame_bytes[gi] = 8'h00;
      end
`else
      assign frame_bytes[gi] = word_reg[31-8*gi -: 8];
`endif
    end
  endgenerate

  assign last_frame = (byte_cnt_reg == BYTE_LAST);

  // The first frame is launched from LOAD; later frames chain on tx_done.
  always_comb begin
    load     = 1'b0;
    byte_sel = byte_cnt_reg;
    if (state_reg == ST_LOAD) begin
      load = 1'b1;
    end else if ((state_reg == ST_WAIT) && tx_done && !last_frame) begin
      load     = 1'b1;
      byte_sel = byte_cnt_reg + 1'b1;
    end
  end

  assign load_data = frame_bytes[byte_sel];

  debug_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .data   (load_data),
    .tx     (tx),
    .tx_done(tx_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      word_reg     <= '0;
      byte_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // The done cycle still counts as end of sweep, so start is not taken there.
          if (start && !done_reg) begin
            busy_reg  <= 1'b1;
            idx_reg   <= '0;
            state_reg <= ST_SELECT;
          end
        end
        ST_SELECT: state_reg <= ST_CAPTURE;
        ST_CAPTURE: begin
          word_reg     <= Debug_out;
          byte_cnt_reg <= '0;
          state_reg    <= ST_LOAD;
        end
        ST_LOAD: state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (tx_done) begin
            if (!last_frame) begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end else if (idx_reg == IDX_LAST) begin
              state_reg <= ST_NEXT;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= ST_SELECT;
            end
          end
        end
        ST_NEXT: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Debug_source_select = idx_reg;
  assign busy                = busy_reg;
  assign done                = done_reg;

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Bench for debug_reg_dumper: cycle-offset reference model, UART frame decoder,
// and literal expectations for the single-register and full-sweep cases.
module tb_debug_reg_dumper;

  localparam int C = 4;
`ifdef DEBUG_DUMP_HEX_ASCII_EN
  localparam int F = 10;
  localparam int DONE1 = 405;
  localparam int DONE32 = 12898;
  localparam logic [31:0] WORD1 = 32'h00C0FFEE;
`else
  localparam int F = 4;
  localparam int DONE1 = 165;
  localparam int DONE32 = 5218;
  localparam logic [31:0] WORD1 = 32'h12345678;
`endif
  localparam int PER = 3 + 10 * C * F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [31:0] dbg0 = '0;
  logic [31:0] dbg1;
  logic [4:0] sel0, sel1;
  logic busy0, busy1, done0, done1, tx0, tx1;

  int checks = 0, passes = 0, cyc = 0;
  int pos0 = 0, pos1 = 0, lsel0 = 0, lsel1 = 0;
  int done_cnt0 = 0;
  logic [31:0] regs [32];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] exp1 [F];
  logic [7:0] expA [4];
  int dec_on [2];
  int dec_cnt [2];
  logic [7:0] dec_byte [2];

  assign dbg1 = WORD1;

  debug_reg_dumper #(.CLKS_PER_BIT(C), .NUM_REGS(32)) dut32 (
    .clk(clk), .reset(reset), .start(start0), .Debug_out(dbg0),
    .Debug_source_select(sel0), .busy(busy0), .done(done0), .tx(tx0));

  debug_reg_dumper #(.CLKS_PER_BIT(C), .NUM_REGS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .Debug_out(dbg1),
    .Debug_source_select(sel1), .busy(busy1), .done(done1), .tx(tx1));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h at cycle %0d", name, act, req, cyc);
  endtask

  function automatic logic [7:0] frame_byte_m(input logic [31:0] w, input int f);
    int nib;
`ifdef DEBUG_DUMP_HEX_ASCII_EN
    if (f < 8) begin
      nib = int'((w >> (28 - 4 * f)) & 32'hF);
      return (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
    end
    nib = 0;
    return (f == 8) ? 8'h0D : 8'h0A;
`else
    nib = int'((w >> (24 - 8 * f)) & 32'hFF);
    return 8'(nib);
`endif
  endfunction

  // Expected {tx, busy, done, select} for a sweep p cycles after acceptance.
  function automatic logic [7:0] model_out(input int which, input int p, input int n, input int last_sel);
    int d, r, q, o, b;
    logic txv;
    logic [7:0] by;
    logic [31:0] w;
    if (p == 0) return {1'b1, 1'b0, 1'b0, 5'(last_sel)};
    d = p - 1;
    if (d < n * PER) begin
      r = d / PER;
      q = d % PER;
      txv = 1'b1;
      if (q >= 3) begin
        w = (which == 0) ? regs[r] : WORD1;
        o = (q - 3) % (10 * C);
        b = o / C;
        by = frame_byte_m(w, (q - 3) / (10 * C));
        if (b == 0) txv = 1'b0;
        else if (b <= 8) txv = by[b-1];
      end
      return {txv, 1'b1, 1'b0, 5'(r)};
    end
    if (d == n * PER) return {1'b1, 1'b1, 1'b0, 5'(n - 1)};
    return {1'b1, 1'b0, 1'b1, 5'(n - 1)};
  endfunction

  // Model position update: start only taken while fully idle.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      pos0 = 0; pos1 = 0; lsel0 = 0; lsel1 = 0;
    end else begin
      if (pos0 == 0) begin if (start0) pos0 = 1; end
      else if (pos0 == 32 * PER + 2) begin pos0 = 0; lsel0 = 31; end
      else pos0++;
      if (pos1 == 0) begin if (start1) pos1 = 1; end
      else if (pos1 == PER + 2) begin pos1 = 0; lsel1 = 0; end
      else pos1++;
    end
  end

  // Per-cycle compare, register-file stimulus, and frame decoding.
  initial forever begin
    logic txs;
    int c;
    @(negedge clk);
    chk("dut32 outputs", {24'h0, tx0, busy0, done0, sel0}, {24'h0, model_out(0, pos0, 32, lsel0)});
    chk("dut1 outputs", {24'h0, tx1, busy1, done1, sel1}, {24'h0, model_out(1, pos1, 1, lsel1)});
    if (done0) done_cnt0++;
    if (!reset && pos0 > 0 && (pos0 - 1) < 32 * PER && ((pos0 - 1) % PER) == 1)
      dbg0 = regs[sel0];
    else
      dbg0 = $urandom;
    for (int k = 0; k < 2; k++) begin
      txs = (k == 0) ? tx0 : tx1;
      if (reset) dec_on[k] = 0;
      else if (dec_on[k] != 0) begin
        dec_cnt[k]++;
        c = dec_cnt[k];
        if ((c % C) == C / 2 && c / C >= 1 && c / C <= 8) dec_byte[k][c/C-1] = txs;
        if (c == 9 * C + C / 2) begin
          dec_on[k] = 0;
          if (k == 0) q0.push_back(dec_byte[k]); else q1.push_back(dec_byte[k]);
          $display("dut%0d frame byte %02h stop %b at cycle %0d", (k == 0) ? 32 : 1, dec_byte[k], txs, cyc);
        end
      end else if (txs == 1'b0) begin
        dec_on[k] = 1;
        dec_cnt[k] = 0;
      end
    end
  end

  task automatic wait_done(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((which == 0) ? done0 : done1) === 1'b1) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++;
      $display("FAIL done timeout dut%0d: no done within %0d cycles", which, budget);
    end
  endtask

  task automatic wait_pos(input int tgt);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (pos0 == tgt) return;
    end
    checks++;
    $display("FAIL position timeout: model never reached %0d", tgt);
  endtask

  initial begin
    int t0, at, base;
`ifdef DEBUG_DUMP_HEX_ASCII_EN
    exp1 = '{8'h30, 8'h30, 8'h43, 8'h30, 8'h46, 8'h46, 8'h45, 8'h45, 8'h0D, 8'h0A};
    expA = '{8'h41, 8'h35, 8'h30, 8'h30};
`else
    exp1 = '{8'h12, 8'h34, 8'h56, 8'h78};
    expA = '{8'hA5, 8'h00, 8'h00, 8'h00};
`endif
    for (int i = 0; i < 32; i++) regs[i] = 32'hA5000000 | 32'(i);
    dec_on = '{0, 0};
    dec_cnt = '{0, 0};
    repeat (3) @(negedge clk);
    reset = 1'b0;

    repeat (100) @(negedge clk);
    chk("idle tx", {31'h0, tx0}, 32'h1);
    chk("idle busy", {31'h0, busy0}, 32'h0);
    chk("idle select", {27'h0, sel0}, 32'h0);

    // Single register
    @(negedge clk); start1 = 1'b1; t0 = cyc;
    @(negedge clk); start1 = 1'b0;
    wait_done(1, 1000, at);
    chk("single done latency", 32'(at - t0), 32'(DONE1));
    chk("single frame count", 32'(q1.size()), 32'(F));
    for (int i = 0; i < F; i++)
      if (i < q1.size()) chk("single frame byte", {24'h0, q1[i]}, {24'h0, exp1[i]});

    // Full sweep with fixed register file
    q0.delete();
    base = done_cnt0;
    @(negedge clk); start0 = 1'b1; t0 = cyc;
    @(negedge clk); start0 = 1'b0;
    wait_done(0, 20000, at);
    chk("sweep done latency", 32'(at - t0), 32'(DONE32));
    chk("sweep frame count", 32'(q0.size()), 32'(32 * F));
    for (int i = 0; i < 4; i++)
      if (i < q0.size()) chk("x0 frame byte", {24'h0, q0[i]}, {24'h0, expA[i]});
    repeat (10) @(negedge clk);
    chk("sweep done pulses", 32'(done_cnt0 - base), 32'h1);

    // Random register file, start pulsed during register 5 data
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    base = done_cnt0;
    @(negedge clk); start0 = 1'b1; t0 = cyc;
    @(negedge clk); start0 = 1'b0;
    wait_pos(1 + 5 * PER + 3 + 2 * C);
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_done(0, 20000, at);
    chk("busy-start done latency", 32'(at - t0), 32'(DONE32));
    // start held across the done cycle and the following one
    start0 = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[3][31:24] = 8'h00;
    @(negedge clk);
    chk("start on done ignored", {31'h0, busy0}, 32'h0);
    @(negedge clk);
    chk("start after done taken", {31'h0, busy0}, 32'h1);
    start0 = 1'b0;
    chk("busy-start done pulses", 32'(done_cnt0 - base), 32'h1);

    // Reset during register 3 data bit 3 (a zero bit)
    base = done_cnt0;
    wait_pos(1 + 3 * PER + 3 + 4 * C + 1);
    #2 reset = 1'b1;
    #1;
    chk("reset tx", {31'h0, tx0}, 32'h1);
    chk("reset busy", {31'h0, busy0}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("reset no done", 32'(done_cnt0 - base), 32'h0);
    chk("reset select", {27'h0, sel0}, 32'h0);
    @(negedge clk); start0 = 1'b1; t0 = cyc;
    @(negedge clk); start0 = 1'b0;
    chk("restart select", {27'h0, sel0}, 32'h0);
    chk("restart busy", {31'h0, busy0}, 32'h1);
    wait_done(0, 20000, at);
    chk("restart done latency", 32'(at - t0), 32'(DONE32));

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
